// File: rtl/fpu_pkg.sv
// Shared FPU definitions: operation selects, canonical NaN and the add/sub issuer state encoding.
package fpu_pkg;

  localparam logic        FPU_ADD = 1'b0;
  localparam logic        FPU_SUB = 1'b1;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_WB      = 2'd3
  } issuer_state_e;

endpackage

// File: rtl/fpu_watchdog.sv
// Saturating cycle counter with synchronous clear; flags expiry when the count reaches TIMEOUT_CYCLES-1.
module fpu_watchdog #(
  parameter int TIMEOUT_CYCLES = 32,
  parameter int CNT_W          = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  // Clear wins over enable; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fpu_addsub_issuer.sv
// Issues one add/sub at a time to the FPU over a start/done level handshake, with a watchdog,
// and returns the result (or a qNaN on timeout) through a valid/ready writeback port.
module fpu_addsub_issuer
  import fpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32,
  parameter int CNT_W          = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  output logic        fpu_start,
  output logic [31:0] fpu_n1,
  output logic [31:0] fpu_n2,
  output logic        fpu_sel,
  input  logic [31:0] fpu_result,
  input  logic        fpu_done,
  input  logic        fpu_busy,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_err,
  output logic        stall
);

  issuer_state_e state, state_nxt;

  logic        start_nxt, sel_nxt, valid_nxt, err_nxt;
  logic [31:0] n1_nxt, n2_nxt, data_nxt;
  logic [4:0]  rd_nxt;
  logic        wd_clear, wd_enable, wd_expired;

  // The FPU's busy line is observed for debug only and never influences issue.
  logic unused_busy;
  assign unused_busy = fpu_busy;

  fpu_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  assign req_ready = (state == ST_IDLE);
  assign stall     = (state != ST_IDLE);

  // The watchdog is restarted on leaving ISSUE so RELEASE gets its own full timeout window.
  always_comb begin
    state_nxt = state;
    start_nxt = fpu_start;
    n1_nxt    = fpu_n1;
    n2_nxt    = fpu_n2;
    sel_nxt   = fpu_sel;
    rd_nxt    = wb_rd;
    data_nxt  = wb_data;
    err_nxt   = wb_err;
    valid_nxt = wb_valid;
    wd_clear  = 1'b0;
    wd_enable = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          n1_nxt    = req_rs1;
          n2_nxt    = req_rs2;
          sel_nxt   = req_op;
          rd_nxt    = req_rd;
          start_nxt = 1'b1;
          wd_clear  = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_enable = 1'b1;
        if (fpu_done) begin
          data_nxt  = fpu_result;
          err_nxt   = 1'b0;
          start_nxt = 1'b0;
          wd_clear  = 1'b1;
          state_nxt = ST_RELEASE;
        end else if (wd_expired) begin
          data_nxt  = FP_QNAN;
          err_nxt   = 1'b1;
          start_nxt = 1'b0;
          wd_clear  = 1'b1;
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        wd_enable = 1'b1;
        if (!fpu_done) begin
          valid_nxt = 1'b1;
          state_nxt = ST_WB;
        end else if (wd_expired) begin
          valid_nxt = 1'b1;
          data_nxt  = FP_QNAN;
          err_nxt   = 1'b1;
          state_nxt = ST_WB;
        end
      end
      ST_WB: begin
        if (wb_ready) begin
          valid_nxt = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      fpu_start <= 1'b0;
      fpu_n1    <= '0;
      fpu_n2    <= '0;
      fpu_sel   <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      wb_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      fpu_start <= start_nxt;
      fpu_n1    <= n1_nxt;
      fpu_n2    <= n2_nxt;
      fpu_sel   <= sel_nxt;
      wb_valid  <= valid_nxt;
      wb_rd     <= rd_nxt;
      wb_data   <= data_nxt;
      wb_err    <= err_nxt;
    end
  end

endmodule
